// File: rtl/hwpe_ctrl_regfile_bist_pkg.sv
// Shared types for the HWPE controller register file with March C- self-test.
package hwpe_ctrl_regfile_bist_package;

  localparam int unsigned ERR_CNT_WIDTH_DEFAULT = 16;

  typedef enum logic [3:0] {
    BIST_IDLE,
    BIST_M0,
    BIST_M1,
    BIST_M2,
    BIST_M3,
    BIST_M4,
    BIST_M5,
    BIST_DRAIN,
    BIST_DONE
  } bist_state_e;

  typedef enum logic [2:0] {
    ELEM_M0 = 3'd0,
    ELEM_M1 = 3'd1,
    ELEM_M2 = 3'd2,
    ELEM_M3 = 3'd3,
    ELEM_M4 = 3'd4,
    ELEM_M5 = 3'd5
  } march_elem_e;

  function automatic march_elem_e state_to_elem(input bist_state_e s);
    march_elem_e e;
    unique case (s)
      BIST_M1: e = ELEM_M1;
      BIST_M2: e = ELEM_M2;
      BIST_M3: e = ELEM_M3;
      BIST_M4: e = ELEM_M4;
      BIST_M5: e = ELEM_M5;
      default: e = ELEM_M0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/hwpe_ctrl_regfile_bist_if.sv
// Functional register-file access port (one read, one byte-enabled write).
interface hwpe_ctrl_regfile_bist_if #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned NUM_BYTE = DATA_WIDTH / 8;

  logic                  ReadEnable;
  logic [ADDR_WIDTH-1:0] ReadAddr;
  logic [DATA_WIDTH-1:0] ReadData;
  logic                  WriteEnable;
  logic [ADDR_WIDTH-1:0] WriteAddr;
  logic [DATA_WIDTH-1:0] WriteData;
  logic [NUM_BYTE-1:0]   WriteBE;

  modport master (
    output ReadEnable, ReadAddr, WriteEnable, WriteAddr, WriteData, WriteBE,
    input  ReadData
  );

  modport slave (
    input  ReadEnable, ReadAddr, WriteEnable, WriteAddr, WriteData, WriteBE,
    output ReadData
  );
endinterface

// File: rtl/hwpe_ctrl_regfile_bist_engine.sv
// March C- sequencer: address/phase stepping, read compare pipeline, status capture.
module hwpe_ctrl_regfile_bist_engine
  import hwpe_ctrl_regfile_bist_package::*;
#(
  parameter int unsigned           ADDR_WIDTH    = 5,
  parameter int unsigned           DATA_WIDTH    = 32,
  parameter int unsigned           ERR_CNT_WIDTH = ERR_CNT_WIDTH_DEFAULT,
  parameter logic [DATA_WIDTH-1:0] BACKGROUND    = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     start,
  input  logic [DATA_WIDTH-1:0]    rdata,
  output logic                     mem_re,
  output logic                     mem_we,
  output logic [ADDR_WIDTH-1:0]    mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  output logic                     busy,
  output logic                     done,
  output logic                     fail,
  output logic [ADDR_WIDTH-1:0]    fail_addr,
  output logic [2:0]               fail_elem,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);
  localparam logic [ADDR_WIDTH-1:0] ADDR_FIRST = '0;
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = '1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] PAT        = BACKGROUND;
  localparam logic [DATA_WIDTH-1:0] PAT_N      = ~BACKGROUND;

  bist_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  phase_q, phase_d;
  logic                  start_accept;
  logic                  descending, elem_last;
  logic                  rd_issue;
  logic [DATA_WIDTH-1:0] rd_exp;

  logic                  cmp_valid_q;
  logic [DATA_WIDTH-1:0] cmp_exp_q;
  logic [ADDR_WIDTH-1:0] cmp_addr_q;
  logic [2:0]            cmp_elem_q;
  logic                  mismatch;

  assign busy     = !(state_q == BIST_IDLE || state_q == BIST_DONE);
  assign mem_addr = addr_q;
  assign mismatch = cmp_valid_q && (rdata != cmp_exp_q);

  // Current element state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= BIST_IDLE;
    else        state_q <= state_d;
  end

  // Next state, address/phase stepping and memory commands.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    phase_d      = phase_q;
    mem_re       = 1'b0;
    mem_we       = 1'b0;
    mem_wdata    = PAT;
    rd_issue     = 1'b0;
    rd_exp       = PAT;
    start_accept = 1'b0;
    descending   = (state_q == BIST_M3) || (state_q == BIST_M4);
    elem_last    = descending ? (addr_q == ADDR_FIRST) : (addr_q == ADDR_LAST);

    unique case (state_q)
      BIST_IDLE, BIST_DONE: begin
        if (start) begin
          start_accept = 1'b1;
          state_d      = BIST_M0;
          addr_d       = ADDR_FIRST;
          phase_d      = 1'b0;
        end
      end
      BIST_M0: begin
        mem_we    = 1'b1;
        mem_wdata = PAT;
        addr_d    = addr_q + ADDR_ONE;
        if (elem_last) state_d = BIST_M1;
      end
      BIST_M1, BIST_M2, BIST_M3, BIST_M4: begin
        // M1/M3 read P and write ~P; M2/M4 the reverse.
        if (!phase_q) begin
          mem_re   = 1'b1;
          rd_issue = 1'b1;
          rd_exp   = (state_q == BIST_M2 || state_q == BIST_M4) ? PAT_N : PAT;
          phase_d  = 1'b1;
        end else begin
          mem_we    = 1'b1;
          mem_wdata = (state_q == BIST_M2 || state_q == BIST_M4) ? PAT : PAT_N;
          phase_d   = 1'b0;
          addr_d    = descending ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);
          if (elem_last) begin
            unique case (state_q)
              BIST_M1: state_d = BIST_M2;
              BIST_M2: begin state_d = BIST_M3; addr_d = ADDR_LAST;  end
              BIST_M3: state_d = BIST_M4;
              default: begin state_d = BIST_M5; addr_d = ADDR_FIRST; end
            endcase
          end
        end
      end
      BIST_M5: begin
        mem_re   = 1'b1;
        rd_issue = 1'b1;
        rd_exp   = PAT;
        addr_d   = addr_q + ADDR_ONE;
        if (elem_last) state_d = BIST_DRAIN;
      end
      BIST_DRAIN: state_d = BIST_DONE;
      default:    state_d = BIST_IDLE;
    endcase

    if (clear) begin
      state_d      = BIST_IDLE;
      phase_d      = 1'b0;
      mem_re       = 1'b0;
      mem_we       = 1'b0;
      rd_issue     = 1'b0;
      start_accept = 1'b0;
    end
  end

  // Address, phase and the one-deep compare pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      phase_q     <= 1'b0;
      cmp_valid_q <= 1'b0;
      cmp_exp_q   <= '0;
      cmp_addr_q  <= '0;
      cmp_elem_q  <= '0;
    end else begin
      addr_q      <= addr_d;
      phase_q     <= phase_d;
      cmp_valid_q <= rd_issue;
      if (rd_issue) begin
        cmp_exp_q  <= rd_exp;
        cmp_addr_q <= addr_q;
        cmp_elem_q <= state_to_elem(state_q);
      end
    end
  end

  // Sticky status: cleared on clear or accepted start, first failure captured once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done      <= 1'b0;
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_elem <= '0;
      err_count <= '0;
    end else if (clear || start_accept) begin
      done      <= 1'b0;
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_elem <= '0;
      err_count <= '0;
    end else begin
      if (state_q == BIST_DRAIN) done <= 1'b1;
      if (mismatch) begin
        if (err_count != '1) err_count <= err_count + ERR_CNT_WIDTH'(1);
        if (!fail) begin
          fail      <= 1'b1;
          fail_addr <= cmp_addr_q;
          fail_elem <= cmp_elem_q;
        end
      end
    end
  end
endmodule

// File: rtl/register_file_1r_1w_all.sv
// Byte-enabled register file: registered read port, full contents exported.
module register_file_1r_1w_all #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_BYTE   = DATA_WIDTH / 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               ReadEnable,
  input  logic [ADDR_WIDTH-1:0]              ReadAddr,
  output logic [DATA_WIDTH-1:0]              ReadData,
  input  logic                               WriteEnable,
  input  logic [ADDR_WIDTH-1:0]              WriteAddr,
  input  logic [DATA_WIDTH-1:0]              WriteData,
  input  logic [NUM_BYTE-1:0]                WriteBE,
  output logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0] MemContent
);
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_word;

  assign rdata_word = mem[ReadAddr];

  // Storage is intentionally not reset; only enabled bytes are updated.
  always_ff @(posedge clk) begin
    if (WriteEnable) begin
      for (int unsigned b = 0; b < NUM_BYTE; b++) begin
        if (WriteBE[b]) mem[WriteAddr][8*b +: 8] <= WriteData[8*b +: 8];
      end
    end
  end

  // Read data register holds its value between read requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          ReadData <= '0;
    else if (ReadEnable) ReadData <= rdata_word;
  end

  // Flatten the array for the contents port.
  always_comb begin
    MemContent = '0;
    for (int unsigned w = 0; w < DEPTH; w++) begin
      MemContent[w*DATA_WIDTH +: DATA_WIDTH] = mem[w];
    end
  end
endmodule

// File: rtl/hwpe_ctrl_regfile_bist.sv
// Register file wrapper: functional port or BIST engine drives the array.
module hwpe_ctrl_regfile_bist
  import hwpe_ctrl_regfile_bist_package::*;
#(
  parameter int unsigned           ADDR_WIDTH    = 5,
  parameter int unsigned           DATA_WIDTH    = 32,
  parameter int unsigned           NUM_BYTE      = DATA_WIDTH / 8,
  parameter logic [DATA_WIDTH-1:0] BACKGROUND    = '0,
  parameter int unsigned           ERR_CNT_WIDTH = ERR_CNT_WIDTH_DEFAULT
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  clear,
  hwpe_ctrl_regfile_bist_if.slave               rf,
  output logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0] MemContent,
  input  logic                                  bist_start,
  output logic                                  bist_busy,
  output logic                                  bist_done,
  output logic                                  bist_fail,
  output logic [ADDR_WIDTH-1:0]                 bist_fail_addr,
  output logic [2:0]                            bist_fail_elem,
  output logic [ERR_CNT_WIDTH-1:0]              bist_err_count
);
  logic                  eng_re, eng_we;
  logic [ADDR_WIDTH-1:0] eng_addr;
  logic [DATA_WIDTH-1:0] eng_wdata;

  logic                  rf_re, rf_we;
  logic [ADDR_WIDTH-1:0] rf_raddr, rf_waddr;
  logic [DATA_WIDTH-1:0] rf_wdata, rf_rdata;
  logic [NUM_BYTE-1:0]   rf_be;

  assign rf.ReadData = rf_rdata;

  // Engine owns the array while busy; functional requests are dropped then.
  always_comb begin
    rf_re    = rf.ReadEnable;
    rf_raddr = rf.ReadAddr;
    rf_we    = rf.WriteEnable;
    rf_waddr = rf.WriteAddr;
    rf_wdata = rf.WriteData;
    rf_be    = rf.WriteBE;
    if (bist_busy) begin
      rf_re    = eng_re;
      rf_raddr = eng_addr;
      rf_we    = eng_we;
      rf_waddr = eng_addr;
      rf_wdata = eng_wdata;
      rf_be    = '1;
    end
  end

  hwpe_ctrl_regfile_bist_engine #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH),
    .ERR_CNT_WIDTH (ERR_CNT_WIDTH),
    .BACKGROUND    (BACKGROUND)
  ) u_engine (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .start     (bist_start),
    .rdata     (rf_rdata),
    .mem_re    (eng_re),
    .mem_we    (eng_we),
    .mem_addr  (eng_addr),
    .mem_wdata (eng_wdata),
    .busy      (bist_busy),
    .done      (bist_done),
    .fail      (bist_fail),
    .fail_addr (bist_fail_addr),
    .fail_elem (bist_fail_elem),
    .err_count (bist_err_count)
  );

  register_file_1r_1w_all #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_BYTE   (NUM_BYTE)
  ) u_rf (
    .clk         (clk),
    .rst_n       (rst_n),
    .ReadEnable  (rf_re),
    .ReadAddr    (rf_raddr),
    .ReadData    (rf_rdata),
    .WriteEnable (rf_we),
    .WriteAddr   (rf_waddr),
    .WriteData   (rf_wdata),
    .WriteBE     (rf_be),
    .MemContent  (MemContent)
  );
endmodule
